// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-lite core: opcodes, FSM states,
// internal operation codes and the instruction decoder.
package mips_mc_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BGTZ  = 6'h07;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        OP_ADDU, OP_SUBU, OP_ORI, OP_LUI, OP_LW, OP_SW,
        OP_BEQ, OP_BGTZ, OP_J, OP_JAL, OP_JR
    } op_e;

    typedef struct packed {
        logic        valid;
        op_e         op;
        logic [31:0] imm;
    } decoded_t;

    // The immediate is extended here so EXEC never needs to look at the opcode again.
    function automatic decoded_t decode_ir(input logic [31:0] ir);
        decoded_t d;
        d.valid = 1'b1;
        d.op    = OP_ADDU;
        d.imm   = {{16{ir[15]}}, ir[15:0]};
        case (ir[31:26])
            OPC_RTYPE: begin
                case (ir[5:0])
                    FN_ADDU: d.op = OP_ADDU;
                    FN_SUBU: d.op = OP_SUBU;
                    FN_JR:   d.op = OP_JR;
                    default: d.valid = 1'b0;
                endcase
            end
            OPC_ORI: begin
                d.op  = OP_ORI;
                d.imm = {16'h0000, ir[15:0]};
            end
            OPC_LUI: begin
                d.op  = OP_LUI;
                d.imm = {ir[15:0], 16'h0000};
            end
            OPC_LW:   d.op = OP_LW;
            OPC_SW:   d.op = OP_SW;
            OPC_BEQ:  d.op = OP_BEQ;
            OPC_BGTZ: d.op = OP_BGTZ;
            OPC_J:    d.op = OP_J;
            OPC_JAL:  d.op = OP_JAL;
            default:  d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32x32 general-purpose register file: two asynchronous read ports, one
// synchronous write port, asynchronous active-low clear. $0 is never written.
module mips_mc_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs_data = regs[rs];
    assign rt_data = regs[rt];

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-lite core: one FSM sequences fetch/decode/execute/memory/
// writeback over a single req/ack memory port, with a sticky trap state.
module mips_multicycle
    import mips_mc_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              retire,
    output logic [31:0]       retire_pc,
    output logic              trap
);

    state_e      state;
    op_e         op;
    logic [31:0] pc, cur_pc, ir, a, b, imm, alu_out, mdr;
    logic [31:0] alu_res, br_target, jmp_target;
    logic [31:0] rf_rs_data, rf_rt_data, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        rf_we, is_ctrl, taken;
    decoded_t    dec;

    assign dec = decode_ir(ir);

    mips_mc_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs      (ir[25:21]),
        .rt      (ir[20:16]),
        .rs_data (rf_rs_data),
        .rt_data (rf_rt_data),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    always_comb begin
        alu_res = a + imm;
        case (op)
            OP_ADDU: alu_res = a + b;
            OP_SUBU: alu_res = a - b;
            OP_ORI:  alu_res = a | imm;
            OP_LUI:  alu_res = imm;
            default: alu_res = a + imm;
        endcase
    end

    // pc already points past the instruction by the time EXEC runs.
    assign br_target  = pc + {imm[29:0], 2'b00};
    assign jmp_target = {pc[31:28], ir[25:0], 2'b00};
    assign taken      = (op == OP_BEQ && a == b) || (op == OP_BGTZ && $signed(a) > 32'sd0);
    assign is_ctrl    = op inside {OP_BEQ, OP_BGTZ, OP_J, OP_JAL, OP_JR};

    assign rf_we    = (state == S_WB) || (state == S_EXEC && op == OP_JAL);
    assign rf_waddr = (state != S_WB) ? 5'd31 :
                      (op == OP_ADDU || op == OP_SUBU) ? ir[15:11] : ir[20:16];
    assign rf_wdata = (state != S_WB) ? pc : (op == OP_LW) ? mdr : alu_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            op      <= OP_ADDU;
            pc      <= RESET_PC;
            cur_pc  <= '0;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (pc[1:0] != 2'b00) begin
                        state <= S_TRAP;
                    end else if (mem_ack) begin
                        ir     <= mem_rdata;
                        cur_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= rf_rs_data;
                    b     <= rf_rt_data;
                    op    <= dec.op;
                    imm   <= dec.imm;
                    state <= dec.valid ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    case (op)
                        OP_BEQ, OP_BGTZ: begin
                            if (taken) pc <= br_target;
                            state <= S_FETCH;
                        end
                        OP_J, OP_JAL: begin
                            pc    <= jmp_target;
                            state <= S_FETCH;
                        end
                        OP_JR: begin
                            pc    <= a;
                            state <= S_FETCH;
                        end
                        OP_LW, OP_SW: state <= (alu_res[1:0] != 2'b00) ? S_TRAP : S_MEM;
                        default:      state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_LW) begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Port outputs are decoded from state so a fetch can issue in its very first cycle.
    assign mem_req   = reset && ((state == S_FETCH && pc[1:0] == 2'b00) || state == S_MEM);
    assign mem_we    = mem_req && state == S_MEM && op == OP_SW;
    assign mem_addr  = !mem_req ? '0 :
                       (state == S_MEM) ? alu_out[ADDR_W-1:0] : pc[ADDR_W-1:0];
    assign mem_wdata = mem_we ? b : '0;
    assign retire    = reset && ((state == S_WB) || (state == S_EXEC && is_ctrl) ||
                                 (state == S_MEM && op == OP_SW && mem_ack));
    assign retire_pc = retire ? cur_pc : '0;
    assign trap      = (state == S_TRAP);

endmodule
